arm7tdmi_mem_bridge: RTL and testbench

Memory-side bridge directly downstream of `arm7tdmi_cache_subsystem`. It accepts the cache subsystem's memory requests: single writes, and single or burst line-fill reads. It sequences them onto a simple request/acknowledge external memory port, one word per beat, and returns read data as registered `mem_valid` pulses. It also tracks external stall cycles for performance analysis.

---
 rtl/arm7tdmi_mem_bridge_if.sv | 45 ++++
 rtl/arm7tdmi_mem_bridge.sv | 137 +++++++++++++
 tb/tb_arm7tdmi_mem_bridge.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arm7tdmi_mem_bridge_if.sv
// arm7tdmi_mem_bridge_if: bus bundle between the cache subsystem, the memory
// bridge and the external memory port.
//   slave  : bridge view (serves the cache-side request, drives the ext port)
//   master : requester/environment view (drives the cache-side request and
//            answers the ext port)
interface arm7tdmi_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    // cache-side request / response
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_req;
    logic                  mem_write;
    logic [2:0]            mem_burst_len;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_byte_en;
    logic [31:0]           mem_rdata;
    logic                  mem_valid;
    logic                  mem_ready;
    // external memory port
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic                  ext_req;
    logic                  ext_we;
    logic [3:0]            ext_be;
    logic [31:0]           ext_wdata;
    logic [31:0]           ext_rdata;
    logic                  ext_ack;
    // performance counter
    logic [31:0]           stall_cycles;

    modport slave (
        input  mem_addr, mem_req, mem_write, mem_burst_len, mem_wdata, mem_byte_en,
        output mem_rdata, mem_valid, mem_ready,
        output ext_addr, ext_req, ext_we, ext_be, ext_wdata,
        input  ext_rdata, ext_ack,
        output stall_cycles
    );

    modport master (
        output mem_addr, mem_req, mem_write, mem_burst_len, mem_wdata, mem_byte_en,
        input  mem_rdata, mem_valid, mem_ready,
        input  ext_addr, ext_req, ext_we, ext_be, ext_wdata,
        output ext_rdata, ext_ack,
        input  stall_cycles
    );
endinterface

// File: rtl/arm7tdmi_mem_bridge.sv
// arm7tdmi_mem_bridge: sequences cache-side single writes and burst reads onto a
// req/ack external port, one word per beat, and counts external stall cycles.
// Build option: ARM7TDMI_MEMBRIDGE_WBUF_EN posts writes into a one-entry buffer
// (write completion reported immediately, drained through WR_BEAT).
module arm7tdmi_mem_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    arm7tdmi_mem_bridge_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BEAT = 2'd1,
        WR_BEAT = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            cnt_q;
    logic                  ext_req_q;
    logic                  ext_we_q;
    logic [3:0]            ext_be_q;
    logic [31:0]           ext_wdata_q;
    logic [31:0]           mem_rdata_q;
    logic                  mem_valid_q;
    logic                  mem_ready_q;
    logic [31:0]           stall_q;

    logic [ADDR_WIDTH-1:0] req_addr_d;
    logic [ADDR_WIDTH-1:0] addr_inc_d;
    logic [31:0]           stall_d;
    logic                  unused_addr_lsbs;

    // word-align the incoming address; next beat address wraps modulo 2^ADDR_WIDTH
    assign req_addr_d       = {bus.mem_addr[ADDR_WIDTH-1:2], 2'b00};
    assign addr_inc_d       = addr_q + ADDR_WIDTH'(4);
    assign unused_addr_lsbs = ^bus.mem_addr[1:0];

    // stall counter saturates at all-ones
    assign stall_d = (stall_q == 32'hFFFF_FFFF) ? stall_q : stall_q + 32'd1;

    // request/beat sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= 3'd0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_be_q    <= 4'b0000;
            ext_wdata_q <= 32'd0;
            mem_rdata_q <= 32'd0;
            mem_valid_q <= 1'b0;
            mem_ready_q <= 1'b1;
        end else begin
            mem_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.mem_req) begin
                        addr_q      <= req_addr_d;
                        cnt_q       <= bus.mem_burst_len;
                        ext_req_q   <= 1'b1;
                        mem_ready_q <= 1'b0;
                        if (bus.mem_write) begin
                            ext_we_q    <= 1'b1;
                            ext_be_q    <= bus.mem_byte_en;
                            ext_wdata_q <= bus.mem_wdata;
                            state_q     <= WR_BEAT;
`ifdef ARM7TDMI_MEMBRIDGE_WBUF_EN
                            // posted write: completion reported on acceptance
                            mem_valid_q <= 1'b1;
`endif
                        end else begin
                            ext_we_q    <= 1'b0;
                            ext_be_q    <= 4'b1111;
                            state_q     <= RD_BEAT;
                        end
                    end
                end
                RD_BEAT: begin
                    if (bus.ext_ack) begin
                        mem_rdata_q <= bus.ext_rdata;
                        mem_valid_q <= 1'b1;
                        if (cnt_q != 3'd0) begin
                            cnt_q  <= cnt_q - 3'd1;
                            addr_q <= addr_inc_d;
                        end else begin
                            ext_req_q   <= 1'b0;
                            mem_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                WR_BEAT: begin
                    if (bus.ext_ack) begin
                        ext_req_q   <= 1'b0;
                        ext_we_q    <= 1'b0;
                        mem_ready_q <= 1'b1;
                        state_q     <= IDLE;
`ifdef ARM7TDMI_MEMBRIDGE_WBUF_EN
                        // buffered write was already reported; drain is silent
`else
                        mem_valid_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    ext_req_q   <= 1'b0;
                    mem_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // count cycles where the external port is requested but not acknowledged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else if (ext_req_q && !bus.ext_ack) begin
            stall_q <= stall_d;
        end
    end

    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_ready    = mem_ready_q;
    assign bus.ext_addr     = addr_q;
    assign bus.ext_req      = ext_req_q;
    assign bus.ext_we       = ext_we_q;
    assign bus.ext_be       = ext_be_q;
    assign bus.ext_wdata    = ext_wdata_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_arm7tdmi_mem_bridge.sv
// tb_arm7tdmi_mem_bridge: directed + randomized bench for arm7tdmi_mem_bridge.
// An external memory responder with configurable wait states answers the ext
// port; expected beats, read data, cycle timing and stall counts come from a
// transaction-level model of the bridge's behaviour.
module tb_arm7tdmi_mem_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arm7tdmi_mem_bridge_if #(.ADDR_WIDTH(32)) bus ();

    arm7tdmi_mem_bridge #(.ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int unsigned cy;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        int unsigned cy;
    } vld_t;

    beat_t       beat_q[$];
    vld_t        vld_q[$];
    logic [31:0] mem [logic [31:0]];
    int          waits = 0;
    int          wcnt = 0;
    logic [63:0] stall_m = 0;
    logic [31:0] rdata_m = 0;

    // edge counter: the interval after edge k is cycle k+1
    always @(posedge clk) cyc <= cyc + 1;

    // external memory responder and output monitor (mid-cycle)
    always @(negedge clk) begin
        if (bus.mem_valid) vld_q.push_back('{bus.mem_rdata, cyc + 1});
        if (rst_n && bus.ext_req) begin
            if (wcnt >= waits) begin
                bus.ext_ack   = 1'b1;
                bus.ext_rdata = mem.exists(bus.ext_addr) ? mem[bus.ext_addr] : 32'hBAD0_0000;
                beat_q.push_back('{bus.ext_addr, bus.ext_we, bus.ext_be, bus.ext_wdata, cyc + 1});
                wcnt = 0;
            end else begin
                bus.ext_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.ext_ack = 1'b0;
            wcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one transaction: model, issue, wait, compare
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [2:0] blen,
                           input logic [31:0] wd, input logic [3:0] be, input int w,
                           input bit noise);
        logic [31:0] base;
        logic [31:0] ea;
        logic [63:0] exp_st;
        int          n;
        int unsigned nn;
        int unsigned rdy_cy;
        int unsigned exp_cy;
        base = {addr[31:2], 2'b00};
        n    = wr ? 1 : int'(blen) + 1;
        for (int i = 0; i < n; i++) begin
            ea = base + 32'(4 * i);
            if (!wr && !mem.exists(ea)) mem[ea] = $urandom;
        end
        waits = w;
        for (int k = 0; k < 100 && !bus.mem_ready; k++) begin
            @(posedge clk); #1;
        end
        beat_q.delete();
        vld_q.delete();
        bus.mem_addr      = addr;
        bus.mem_write     = wr;
        bus.mem_burst_len = blen;
        bus.mem_wdata     = wd;
        bus.mem_byte_en   = be;
        bus.mem_req       = 1'b1;
        @(posedge clk); #1;
        nn = cyc;
        bus.mem_req = 1'b0;
        rdy_cy = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus.mem_ready) begin
                bus.mem_req = 1'b0;
                rdy_cy = cyc + 1;
                break;
            end
            if (noise) begin
                bus.mem_req       = 1'($urandom_range(0, 1));
                bus.mem_write     = 1'($urandom_range(0, 1));
                bus.mem_addr      = $urandom;
                bus.mem_burst_len = 3'($urandom_range(0, 7));
                bus.mem_wdata     = $urandom;
                bus.mem_byte_en   = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
        end
        if (rdy_cy == 0) chk("ready_timeout", 0, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        // beats on the external port
        chk("beat_count", beat_q.size(), n);
        for (int i = 0; i < n && i < beat_q.size(); i++) begin
            ea = base + 32'(4 * i);
            chk("beat_addr", beat_q[i].addr, ea);
            chk("beat_we", beat_q[i].we, wr);
            chk("beat_be", beat_q[i].be, wr ? be : 4'b1111);
            if (wr) chk("beat_wdata", beat_q[i].wdata, wd);
            chk("beat_cycle", beat_q[i].cy, nn + 1 + i * (w + 1) + w);
        end
        // responses on the cache side
        chk("valid_count", vld_q.size(), n);
        for (int i = 0; i < n && i < vld_q.size(); i++) begin
            ea = base + 32'(4 * i);
            if (!wr) rdata_m = mem[ea];
            chk("valid_data", vld_q[i].data, rdata_m);
`ifdef ARM7TDMI_MEMBRIDGE_WBUF_EN
            exp_cy = wr ? nn + 1 : nn + 2 + w + i * (w + 1);
`else
            exp_cy = nn + 2 + w + i * (w + 1);
`endif
            chk("valid_cycle", vld_q[i].cy, exp_cy);
        end
        chk("ready_cycle", rdy_cy, nn + 2 + w + (n - 1) * (w + 1));
        exp_st  = stall_m + 64'(w * n);
        stall_m = (exp_st > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : exp_st;
        chk("stall_cycles", bus.stall_cycles, stall_m);
    endtask

    initial begin
        bus.mem_addr      = '0;
        bus.mem_req       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_burst_len = 3'd0;
        bus.mem_wdata     = 32'd0;
        bus.mem_byte_en   = 4'd0;
        bus.ext_ack       = 1'b0;
        bus.ext_rdata     = 32'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.mem_ready, 1'b1);
        chk("rst_ext_be", bus.ext_be, 4'b0000);
        chk("rst_stall", bus.stall_cycles, 32'd0);
        chk("rst_ext_req", bus.ext_req, 1'b0);
        chk("rst_valid", bus.mem_valid, 1'b0);
        chk("rst_ext_addr", bus.ext_addr, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single read, ack tied high
        mem[32'h1000] = 32'hE3A0_0001;
        run_txn(32'h1000, 1'b0, 3'd0, 32'd0, 4'd0, 0, 1'b0);
        chk("single_rdata", bus.mem_rdata, 32'hE3A0_0001);

        // 8-beat burst with 2 wait states per beat
        run_txn(32'h1000, 1'b0, 3'd7, 32'd0, 4'd0, 2, 1'b0);
        chk("burst_stall_16", bus.stall_cycles, 32'd16);

        // unaligned write, ack delayed 3 cycles
        run_txn(32'h3002, 1'b1, 3'd5, 32'hDEAD_BEEF, 4'b0011, 3, 1'b0);

        // address wrap across the top of the space
        run_txn(32'hFFFF_FFFC, 1'b0, 3'd1, 32'd0, 4'd0, 0, 1'b0);

        // zero byte enables still produce a beat
        run_txn(32'h0000_0040, 1'b1, 3'd0, 32'h1234_5678, 4'b0000, 1, 1'b0);

        // request inputs toggled while busy are ignored
        run_txn(32'h4000, 1'b0, 3'd3, 32'd0, 4'd0, 2, 1'b1);

        // reset during beat 2 of a 4-beat burst
        for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(4 * i)] = $urandom;
        waits = 1;
        beat_q.delete();
        vld_q.delete();
        bus.mem_addr      = 32'h2000;
        bus.mem_write     = 1'b0;
        bus.mem_burst_len = 3'd3;
        bus.mem_req       = 1'b1;
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
        for (int k = 0; k < 50 && beat_q.size() < 1; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_beat1_seen", beat_q.size(), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ext_req", bus.ext_req, 1'b0);
        chk("abort_ready", bus.mem_ready, 1'b1);
        chk("abort_valid", bus.mem_valid, 1'b0);
        chk("abort_ext_addr", bus.ext_addr, 32'd0);
        chk("abort_ext_be", bus.ext_be, 4'b0000);
        chk("abort_stall", bus.stall_cycles, 32'd0);
        stall_m = 0;
        rdata_m = 0;
        beat_q.delete();
        vld_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_valid", vld_q.size(), 0);
        chk("abort_no_beat", beat_q.size(), 0);
        run_txn(32'h2000, 1'b0, 3'd0, 32'd0, 4'd0, 1, 1'b0);

        // stall counter saturation
        force dut.stall_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_q;
        #1;
        stall_m = 64'hFFFF_FFFD;
        chk("sat_preload", bus.stall_cycles, 32'hFFFF_FFFD);
        run_txn(32'h5000, 1'b0, 3'd1, 32'd0, 4'd0, 2, 1'b0);
        chk("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);
        run_txn(32'h5100, 1'b1, 3'd0, 32'hCAFE_F00D, 4'b1111, 3, 1'b0);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            run_txn($urandom, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                    $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                    bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
